ram_read_queue: RTL and testbench

RAM_READ_QUEUE -- requirements
Module: ram_read_queue

---
 rtl/ram_read_queue.sv | 149 ++++++++++++++
 tb/tb_ram_read_queue.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_read_queue.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : ram_read_queue                                                  |
// | Purpose  : In-order RAM read request queue. Accepted requests (address +  |
// |            instruction tag) wait in a circular FIFO. When the one-entry     |
// |            response register is free, the head address is presented to     |
// |            a combinational RAM. The returned data and the head tag are      |
// |            captured into the response register.                             |
// | Ports    : clk, rst (sync, active high), flush                              |
// |            req_valid/req_ready/req_addr/req_tag   - request side            |
// |            ram_addr/ram_data                      - combinational RAM port  |
// |            resp_valid/resp_ready/resp_tag/resp_data - response side         |
// |            count - entries waiting in the FIFO (response reg excluded)      |
// | Options  : RAM_READ_QUEUE_BYPASS_EN - with an empty FIFO and a free        |
// |            response slot, an incoming request goes straight to the RAM     |
// |            (one-cycle latency). If undefined, every request passes         |
// |            through the FIFO (two-cycle latency).                           |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module ram_read_queue #(
  parameter int DEPTH  = 8,   // power of two, >= 2
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16,
  parameter int TAG_W  = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [ADDR_W-1:0]        req_addr,
  input  logic [TAG_W-1:0]         req_tag,
  output logic [ADDR_W-1:0]        ram_addr,
  input  logic [DATA_W-1:0]        ram_data,
  output logic                     resp_valid,
  input  logic                     resp_ready,
  output logic [TAG_W-1:0]         resp_tag,
  output logic [DATA_W-1:0]        resp_data,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  // FIFO storage (no reset needed: only entries below count are ever read)
  logic [ADDR_W-1:0] addr_mem_q [DEPTH];
  logic [TAG_W-1:0]  tag_mem_q  [DEPTH];

  logic [PTR_W-1:0]  head_q, head_d;
  logic [PTR_W-1:0]  tail_q, tail_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              resp_valid_q, resp_valid_d;
  logic [TAG_W-1:0]  resp_tag_q, resp_tag_d;
  logic [DATA_W-1:0] resp_data_q, resp_data_d;

  logic push;       // handshake on the request side
  logic slot_free;  // response register can take a new value this edge
  logic pop;        // head entry moves into the response register
  logic byp;        // request goes straight into the response register
  logic fifo_push;  // request is written into the FIFO

  // Full blocks a push even if a pop happens in the same cycle.
  assign req_ready = (count_q != FULL_CNT) && !flush && !rst;
  assign push      = req_valid && req_ready;
  assign slot_free = !resp_valid_q || resp_ready;
  assign pop       = (count_q != '0) && slot_free;

`ifdef RAM_READ_QUEUE_BYPASS_EN
  // Empty FIFO and free slot: the RAM is read with the request address itself.
  assign byp       = push && (count_q == '0) && slot_free;
  assign ram_addr  = byp ? req_addr : addr_mem_q[head_q];
`else
  assign byp       = 1'b0;
  // With an empty FIFO this is the stale head entry; the RAM result is ignored.
  assign ram_addr  = addr_mem_q[head_q];
`endif

  assign fifo_push = push && !byp;

  always_comb begin
    head_d       = head_q;
    tail_d       = tail_q;
    count_d      = count_q;
    resp_valid_d = resp_valid_q;
    resp_tag_d   = resp_tag_q;
    resp_data_d  = resp_data_q;

    if (flush) begin
      // Drop everything pending; head catches up with tail so the FIFO is empty.
      head_d       = tail_q;
      count_d      = '0;
      resp_valid_d = 1'b0;
    end else begin
      if (fifo_push) begin
        tail_d = tail_q + PTR_W'(1);
      end
      if (pop) begin
        head_d = head_q + PTR_W'(1);
      end
      count_d = count_q + CNT_W'(fifo_push) - CNT_W'(pop);

      if (pop) begin
        resp_valid_d = 1'b1;
        resp_tag_d   = tag_mem_q[head_q];
        resp_data_d  = ram_data;
      end else if (byp) begin
        resp_valid_d = 1'b1;
        resp_tag_d   = req_tag;
        resp_data_d  = ram_data;
      end else if (resp_ready) begin
        // Held response consumed with nothing to replace it.
        resp_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (fifo_push) begin
      addr_mem_q[tail_q] <= req_addr;
      tag_mem_q[tail_q]  <= req_tag;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q       <= '0;
      tail_q       <= '0;
      count_q      <= '0;
      resp_valid_q <= 1'b0;
      resp_tag_q   <= '0;
      resp_data_q  <= '0;
    end else begin
      head_q       <= head_d;
      tail_q       <= tail_d;
      count_q      <= count_d;
      resp_valid_q <= resp_valid_d;
      resp_tag_q   <= resp_tag_d;
      resp_data_q  <= resp_data_d;
    end
  end

  assign resp_valid = resp_valid_q;
  assign resp_tag   = resp_tag_q;
  assign resp_data  = resp_data_q;
  assign count      = count_q;

endmodule
`default_nettype wire

// File: tb/tb_ram_read_queue.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_ram_read_queue                                               |
// | Purpose  : Self-checking bench for ram_read_queue (DEPTH=8, 16/16/8 bits). |
// |            Vector table for the basic flow, plus sequences for full queue, |
// |            wrap-around with back-pressure, reset, and push into an empty   |
// |            queue while a response leaves. RAM_READ_QUEUE_BYPASS_EN selects |
// |            the expected latencies.                                          |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_ram_read_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        req_valid;
  logic        req_ready;
  logic [15:0] req_addr;
  logic [7:0]  req_tag;
  logic [15:0] ram_addr;
  logic [15:0] ram_data;
  logic        resp_valid;
  logic        resp_ready;
  logic [7:0]  resp_tag;
  logic [15:0] resp_data;
  logic [3:0]  count;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  // Combinational RAM model
  function automatic logic [15:0] ram_f(input logic [15:0] a);
    case (a)
      16'd52:  ram_f = 16'h0E10;
      16'd54:  ram_f = 16'h0911;
      default: ram_f = {a[7:0] ^ 8'h5A, ~a[7:0]};
    endcase
  endfunction

  assign ram_data = ram_f(ram_addr);

  ram_read_queue #(.DEPTH(8), .ADDR_W(16), .DATA_W(16), .TAG_W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_addr   (req_addr),
    .req_tag    (req_tag),
    .ram_addr   (ram_addr),
    .ram_data   (ram_data),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_tag   (resp_tag),
    .resp_data  (resp_data),
    .count      (count)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        v;
    logic [15:0] a;
    logic [7:0]  t;
    logic        rr;
    logic        fl;
    logic        e_rv;
    logic        chk_td;
    logic [7:0]  e_tag;
    logic [15:0] e_data;
    logic [3:0]  e_cnt;
    logic        e_rdy;
  } vec_t;

  function automatic vec_t mk(input logic v, input logic [15:0] a, input logic [7:0] t,
                              input logic rr, input logic fl, input logic e_rv,
                              input logic chk_td, input logic [7:0] e_tag,
                              input logic [15:0] e_data, input logic [3:0] e_cnt,
                              input logic e_rdy);
    vec_t r;
    r.v = v; r.a = a; r.t = t; r.rr = rr; r.fl = fl; r.e_rv = e_rv;
    r.chk_td = chk_td; r.e_tag = e_tag; r.e_data = e_data; r.e_cnt = e_cnt;
    r.e_rdy = e_rdy;
    return r;
  endfunction

  initial begin
    vec_t        tbl [14];
    logic [15:0] d60;
    int          k;
    int          sent;
    int          got;
    logic        found;
    logic        stall_prev;
    logic [7:0]  sv_tag;
    logic [15:0] sv_data;
    int          q_tag  [$];
    int          q_addr [$];

    d60 = ram_f(16'd60);

    // Each row: inputs for one cycle, outputs observed in that cycle.
`ifdef RAM_READ_QUEUE_BYPASS_EN
    tbl[0]  = mk(1, 16'd52, 8'd0, 1, 0, 0, 0, 8'd0, 16'h0000, 4'd0, 1);
    tbl[1]  = mk(1, 16'd54, 8'd1, 1, 0, 1, 1, 8'd0, 16'h0E10, 4'd0, 1);
    tbl[2]  = mk(0, 16'd0,  8'd0, 1, 0, 1, 1, 8'd1, 16'h0911, 4'd0, 1);
    tbl[3]  = mk(0, 16'd0,  8'd0, 1, 0, 0, 0, 8'd0, 16'h0000, 4'd0, 1);
    tbl[4]  = mk(0, 16'd0,  8'd0, 1, 0, 0, 0, 8'd0, 16'h0000, 4'd0, 1);
    tbl[5]  = mk(1, 16'd60, 8'd2, 0, 0, 0, 0, 8'd0, 16'h0000, 4'd0, 1);
    tbl[6]  = mk(1, 16'd62, 8'd3, 0, 0, 1, 1, 8'd2, d60,      4'd0, 1);
    tbl[7]  = mk(1, 16'd64, 8'd4, 0, 0, 1, 1, 8'd2, d60,      4'd1, 1);
    tbl[8]  = mk(0, 16'd0,  8'd0, 0, 1, 1, 1, 8'd2, d60,      4'd2, 0);
    tbl[9]  = mk(0, 16'd0,  8'd0, 1, 0, 0, 0, 8'd0, 16'h0000, 4'd0, 1);
    tbl[10] = mk(1, 16'd52, 8'd7, 1, 0, 0, 0, 8'd0, 16'h0000, 4'd0, 1);
    tbl[11] = mk(0, 16'd0,  8'd0, 1, 0, 1, 1, 8'd7, 16'h0E10, 4'd0, 1);
    tbl[12] = mk(0, 16'd0,  8'd0, 1, 0, 0, 0, 8'd0, 16'h0000, 4'd0, 1);
    tbl[13] = mk(0, 16'd0,  8'd0, 1, 0, 0, 0, 8'd0, 16'h0000, 4'd0, 1);
`else
    tbl[0]  = mk(1, 16'd52, 8'd0, 1, 0, 0, 0, 8'd0, 16'h0000, 4'd0, 1);
    tbl[1]  = mk(1, 16'd54, 8'd1, 1, 0, 0, 0, 8'd0, 16'h0000, 4'd1, 1);
    tbl[2]  = mk(0, 16'd0,  8'd0, 1, 0, 1, 1, 8'd0, 16'h0E10, 4'd1, 1);
    tbl[3]  = mk(0, 16'd0,  8'd0, 1, 0, 1, 1, 8'd1, 16'h0911, 4'd0, 1);
    tbl[4]  = mk(0, 16'd0,  8'd0, 1, 0, 0, 0, 8'd0, 16'h0000, 4'd0, 1);
    tbl[5]  = mk(1, 16'd60, 8'd2, 0, 0, 0, 0, 8'd0, 16'h0000, 4'd0, 1);
    tbl[6]  = mk(1, 16'd62, 8'd3, 0, 0, 0, 0, 8'd0, 16'h0000, 4'd1, 1);
    tbl[7]  = mk(1, 16'd64, 8'd4, 0, 0, 1, 1, 8'd2, d60,      4'd1, 1);
    tbl[8]  = mk(0, 16'd0,  8'd0, 0, 1, 1, 1, 8'd2, d60,      4'd2, 0);
    tbl[9]  = mk(0, 16'd0,  8'd0, 1, 0, 0, 0, 8'd0, 16'h0000, 4'd0, 1);
    tbl[10] = mk(1, 16'd52, 8'd7, 1, 0, 0, 0, 8'd0, 16'h0000, 4'd0, 1);
    tbl[11] = mk(0, 16'd0,  8'd0, 1, 0, 0, 0, 8'd0, 16'h0000, 4'd1, 1);
    tbl[12] = mk(0, 16'd0,  8'd0, 1, 0, 1, 1, 8'd7, 16'h0E10, 4'd0, 1);
    tbl[13] = mk(0, 16'd0,  8'd0, 1, 0, 0, 0, 8'd0, 16'h0000, 4'd0, 1);
`endif

    // ---------------- reset ----------------
    rst = 1'b1; flush = 1'b0; req_valid = 1'b0; req_addr = '0; req_tag = '0;
    resp_ready = 1'b0;
    repeat (2) begin
      @(negedge clk);
      chk("rst_ready_low", req_ready, 0);
      next_cycle();
    end
    rst = 1'b0;
    @(negedge clk);
    chk("rst_count", count, 0);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_resp_tag", resp_tag, 0);
    chk("rst_resp_data", resp_data, 0);
    chk("rst_ready_after", req_ready, 1);
    next_cycle();

    // ---------------- vector table ----------------
    for (int i = 0; i < 14; i++) begin
      req_valid  = tbl[i].v;
      req_addr   = tbl[i].a;
      req_tag    = tbl[i].t;
      resp_ready = tbl[i].rr;
      flush      = tbl[i].fl;
      @(negedge clk);
      chk($sformatf("vec%0d_resp_valid", i), resp_valid, tbl[i].e_rv);
      chk($sformatf("vec%0d_count", i), count, tbl[i].e_cnt);
      chk($sformatf("vec%0d_req_ready", i), req_ready, tbl[i].e_rdy);
      if (tbl[i].chk_td) begin
        chk($sformatf("vec%0d_resp_tag", i), resp_tag, tbl[i].e_tag);
        chk($sformatf("vec%0d_resp_data", i), resp_data, tbl[i].e_data);
      end
      next_cycle();
    end
    req_valid = 1'b0; flush = 1'b0;

    // ---------------- full queue: 9 requests with resp_ready low ----------------
    resp_ready = 1'b0;
    for (int i = 0; i < 9; i++) begin
      req_valid = 1'b1;
      req_addr  = 16'(100 + 2 * i);
      req_tag   = 8'(i);
      @(negedge clk);
      chk($sformatf("full_push%0d_ready", i), req_ready, 1);
      next_cycle();
    end
    req_addr = 16'd200; req_tag = 8'd99;  // 10th request, must stall
    repeat (2) begin
      @(negedge clk);
      chk("full_count", count, 8);
      chk("full_ready_low", req_ready, 0);
      chk("full_held_valid", resp_valid, 1);
      chk("full_held_tag", resp_tag, 0);
      next_cycle();
    end
    resp_ready = 1'b1;
    @(negedge clk);
    chk("full_ready_low_with_pop", req_ready, 0);
    chk("full_drain_tag0", resp_tag, 0);
    chk("full_drain_data0", resp_data, ram_f(16'd100));
    k = 1;
    for (int c = 0; c < 40 && k < 9; c++) begin
      next_cycle();
      req_valid = 1'b0;
      @(negedge clk);
      if (resp_valid) begin
        chk($sformatf("full_drain_tag%0d", k), resp_tag, 8'(k));
        chk($sformatf("full_drain_data%0d", k), resp_data, ram_f(16'(100 + 2 * k)));
        k++;
      end
    end
    chk("full_drain_all", k, 9);
    next_cycle();
    @(negedge clk);
    chk("full_empty_valid", resp_valid, 0);
    chk("full_empty_count", count, 0);
    next_cycle();

    // ---------------- 20 requests, resp_ready toggling ----------------
    sent = 0; got = 0; stall_prev = 1'b0; sv_tag = '0; sv_data = '0;
    for (int c = 0; c < 200 && got < 20; c++) begin
      req_valid  = (sent < 20);
      req_addr   = 16'(300 + 3 * sent);
      req_tag    = 8'(40 + sent);
      resp_ready = c[0];
      @(negedge clk);
      if (stall_prev) begin
        chk("tog_hold_valid", resp_valid, 1);
        chk("tog_hold_tag", resp_tag, sv_tag);
        chk("tog_hold_data", resp_data, sv_data);
      end
      if (resp_valid && resp_ready) begin
        if (q_tag.size() == 0) begin
          chk("tog_unexpected_resp", resp_tag, 8'hFF);
        end else begin
          chk($sformatf("tog_tag%0d", got), resp_tag, 8'(q_tag[0]));
          chk($sformatf("tog_data%0d", got), resp_data, ram_f(16'(q_addr[0])));
          void'(q_tag.pop_front());
          void'(q_addr.pop_front());
        end
        got++;
      end
      stall_prev = resp_valid && !resp_ready;
      sv_tag     = resp_tag;
      sv_data    = resp_data;
      if (req_valid && req_ready) begin
        q_tag.push_back(40 + sent);
        q_addr.push_back(300 + 3 * sent);
        sent++;
      end
      next_cycle();
    end
    req_valid = 1'b0;
    chk("tog_sent", sent, 20);
    chk("tog_got", got, 20);
    resp_ready = 1'b1;
    repeat (2) next_cycle();

    // ---------------- reset with count = 3 ----------------
    resp_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      req_valid = 1'b1;
      req_addr  = 16'(400 + 2 * i);
      req_tag   = 8'(50 + i);
      @(negedge clk);
      next_cycle();
    end
    req_valid = 1'b0;
    @(negedge clk);
    chk("mrst_pre_count", count, 3);
    chk("mrst_pre_valid", resp_valid, 1);
    next_cycle();
    rst = 1'b1;
    @(negedge clk);
    chk("mrst_ready_low", req_ready, 0);
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    chk("mrst_count", count, 0);
    chk("mrst_valid", resp_valid, 0);
    chk("mrst_data", resp_data, 0);
    chk("mrst_tag", resp_tag, 0);
    chk("mrst_ready_high", req_ready, 1);
    next_cycle();
    resp_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk($sformatf("mrst_stale%0d", i), resp_valid, 0);
      next_cycle();
    end

    // ---------------- push into empty queue while response leaves ----------------
    resp_ready = 1'b0;
    req_valid = 1'b1; req_addr = 16'd52; req_tag = 8'd9;
    @(negedge clk);
    next_cycle();
    req_valid = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 6 && !found; c++) begin
      @(negedge clk);
      if (resp_valid) found = 1'b1;
      else next_cycle();
    end
    chk("emp_held_found", found, 1);
    chk("emp_held_count", count, 0);
    next_cycle();
    req_valid = 1'b1; req_addr = 16'd54; req_tag = 8'd10; resp_ready = 1'b1;
    @(negedge clk);
    chk("emp_leave_valid", resp_valid, 1);
    chk("emp_leave_tag", resp_tag, 9);
    chk("emp_leave_data", resp_data, 16'h0E10);
    chk("emp_push_ready", req_ready, 1);
    next_cycle();
    req_valid = 1'b0;
    @(negedge clk);
`ifdef RAM_READ_QUEUE_BYPASS_EN
    chk("emp_after_count", count, 0);
    chk("emp_after_valid", resp_valid, 1);
    chk("emp_after_tag", resp_tag, 10);
    chk("emp_after_data", resp_data, 16'h0911);
`else
    chk("emp_after_count", count, 1);
    chk("emp_after_valid", resp_valid, 0);
    next_cycle();
    @(negedge clk);
    chk("emp_late_valid", resp_valid, 1);
    chk("emp_late_tag", resp_tag, 10);
    chk("emp_late_data", resp_data, 16'h0911);
`endif
    next_cycle();
    @(negedge clk);
    chk("emp_final_valid", resp_valid, 0);
    chk("emp_final_count", count, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
